// File: rtl/stoch_sched_pkg.sv
// Shared types and helpers for the stochastic decorrelator sequencing controller.
package stoch_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED   = 3'd1,
        WARMUP = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } sched_state_t;

    localparam int unsigned MIN_IDX_W = 1;

    // Index width for a dimension of n elements; a single-element dimension still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? MIN_IDX_W : $clog2(n);
    endfunction

endpackage

// File: rtl/stoch_ones_counter.sv
// Per-element ones counter: synchronous clear, counts bit_in while enabled.
module stoch_ones_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && bit_in) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/stoch_decorr_sched.sv
// Sequencer for a stochastic decorrelator matrix: seed broadcast, warm-up, counted
// measurement window, and a registered random-access readout of the per-element counts.
module stoch_decorr_sched
    import stoch_sched_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = 2,
    parameter int unsigned NUM_COLS   = 2,
    parameter int unsigned LFSR_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned WARM_WIDTH = 8
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [CNT_WIDTH-1:0]                  len,
    input  logic [WARM_WIDTH-1:0]                 warmup,
    input  logic [LFSR_WIDTH-1:0]                 seed,
    output logic                                  seed_load,
    output logic [LFSR_WIDTH-1:0]                 seed_out,
    output logic                                  dp_en,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]     Y_in,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  rd_en,
    input  logic [idx_width(NUM_ROWS)-1:0]        rd_row,
    input  logic [idx_width(NUM_COLS)-1:0]        rd_col,
    output logic [CNT_WIDTH-1:0]                  rd_data,
    output logic                                  rd_valid
);

    localparam int unsigned ROW_W = idx_width(NUM_ROWS);
    localparam int unsigned COL_W = idx_width(NUM_COLS);

    sched_state_t state, state_nx;

    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  run_cnt;
    logic [WARM_WIDTH-1:0] warm_q;
    logic [WARM_WIDTH-1:0] warm_cnt;
    logic                  accept_c;
    logic                  count_en_c;
    logic [CNT_WIDTH-1:0]  rd_sel_c;
    logic [CNT_WIDTH-1:0]  counts [NUM_ROWS][NUM_COLS];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; abort takes priority over every forward transition.
    always_comb begin
        state_nx   = state;
        accept_c   = 1'b0;
        count_en_c = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept_c = 1'b1;
                    state_nx = (len == '0) ? DONE : SEED;
                end
            end
            SEED: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = (warm_q != '0) ? WARMUP : RUN;
                end
            end
            WARMUP: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (warm_cnt == WARM_WIDTH'(1)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    count_en_c = 1'b1;
                    if (run_cnt == CNT_WIDTH'(1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Captured run parameters and phase down-counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_q    <= '0;
            warm_q   <= '0;
            seed_out <= '0;
            warm_cnt <= '0;
            run_cnt  <= '0;
        end else begin
            if (accept_c) begin
                len_q    <= len;
                warm_q   <= warmup;
                seed_out <= seed;
            end

            if (accept_c) begin
                warm_cnt <= '0;
            end else if (state == SEED) begin
                warm_cnt <= warm_q;
            end else if (state == WARMUP) begin
                warm_cnt <= warm_cnt - WARM_WIDTH'(1);
            end

            if (accept_c) begin
                run_cnt <= '0;
            end else if (state_nx == RUN && state != RUN) begin
                run_cnt <= len_q;
            end else if (state == RUN) begin
                run_cnt <= run_cnt - CNT_WIDTH'(1);
            end
        end
    end

    // Control outputs registered from the upcoming state so they align with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seed_load <= 1'b0;
            dp_en     <= 1'b0;
            done      <= 1'b0;
        end else begin
            seed_load <= (state_nx == SEED);
            dp_en     <= (state_nx == WARMUP) || (state_nx == RUN);
            done      <= (state_nx == DONE);
        end
    end

    assign busy = (state != IDLE);

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
        for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
            stoch_ones_counter #(
                .CNT_WIDTH(CNT_WIDTH)
            ) u_cnt (
                .CLK   (CLK),
                .RST   (RST),
                .clr   (accept_c),
                .en    (count_en_c),
                .bit_in(Y_in[i][j]),
                .count (counts[i][j])
            );
        end
    end

    // Read mux; an index with no matching element yields zero.
    always_comb begin
        rd_sel_c = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            for (int j = 0; j < NUM_COLS; j++) begin
                if (rd_row == ROW_W'(i) && rd_col == COL_W'(j)) begin
                    rd_sel_c = counts[i][j];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_sel_c;
            end
        end
    end

endmodule

// File: tb/tb_stoch_decorr_sched.sv
// Randomized bench for stoch_decorr_sched against a cycle-indexed model of the run sequence.
module tb_stoch_decorr_sched;

    localparam int NR = 3;
    localparam int NC = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic              abort;
    logic [15:0]       len;
    logic [7:0]        warmup;
    logic [63:0]       seed;
    logic              seed_load;
    logic [63:0]       seed_out;
    logic              dp_en;
    logic [NR-1:0][NC-1:0] Y_in;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [1:0]        rd_row;
    logic [0:0]        rd_col;
    logic [15:0]       rd_data;
    logic              rd_valid;

    int          total = 0;
    int          bad   = 0;
    int          mc [NR][NC];
    logic [15:0] rd_hold = '0;
    bit          rd_pend = 1'b0;
    logic [63:0] seed_exp = '0;

    stoch_decorr_sched #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .LFSR_WIDTH(64), .CNT_WIDTH(16), .WARM_WIDTH(8)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .len(len), .warmup(warmup),
        .seed(seed), .seed_load(seed_load), .seed_out(seed_out), .dp_en(dp_en), .Y_in(Y_in),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive read, update the model, advance, then check the read port.
    task automatic tick(input bit do_rd, input int row, input int col, input bit clr, input bit cnt);
        rd_en  = do_rd;
        rd_row = 2'(row);
        rd_col = 1'(col);
        if (do_rd) rd_hold = (row < NR) ? 16'(mc[row][col]) : 16'd0;
        rd_pend = do_rd;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NC; j++) begin
                if (clr) mc[i][j] = 0;
                if (cnt && Y_in[i][j]) mc[i][j] = mc[i][j] + 1;
            end
        @(posedge CLK);
        #1;
        check("rd_valid", 64'(rd_valid), 64'(rd_pend));
        check("rd_data", 64'(rd_data), 64'(rd_hold));
    endtask

    task automatic readout();
        for (int i = 0; i <= NR; i++)
            for (int j = 0; j < NC; j++)
                tick(1'b1, i, j, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // mode: 0 random Y, 1 all ones, 2 toggle on element [0][0] only. abort_t is a cycle index (0 = none).
    task automatic do_run(input int l, input int w, input logic [63:0] s, input int abort_t, input int mode);
        int run_first, run_last, endt, ends;
        bit cnt;
        run_first = 2 + w;
        run_last  = 1 + w + l;
        endt      = (l == 0) ? 1 : 2 + w + l;
        ends      = (abort_t != 0 && l != 0) ? abort_t : endt;
        start  = 1'b1;
        abort  = 1'b0;
        len    = 16'(l);
        warmup = 8'(w);
        seed   = s;
        Y_in   = 6'($urandom);
        tick(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'b1, 1'b0);
        seed_exp = s;
        for (int t = 1; t <= ends + 1; t++) begin
            check("busy", 64'(busy), 64'(t <= ends));
            check("seed_load", 64'(seed_load), 64'(l != 0 && t == 1));
            check("dp_en", 64'(dp_en), 64'(l != 0 && t >= 2 && t <= run_last && t <= ends));
            check("done", 64'(done), 64'(t == endt && t <= ends));
            check("seed_out", seed_out, seed_exp);
            if (t <= ends) begin
                start  = 1'($urandom);
                len    = 16'($urandom);
                warmup = 8'($urandom);
                seed   = {$urandom, $urandom};
                abort  = (t == abort_t);
            end else begin
                start = 1'b0;
                abort = 1'b0;
            end
            case (mode)
                1:       Y_in = '1;
                2: begin
                    Y_in = '0;
                    if (t >= run_first) Y_in[0][0] = ((t - run_first) % 2 == 0);
                end
                default: Y_in = 6'($urandom);
            endcase
            cnt = (l != 0) && (t >= run_first) && (t <= run_last) && (t <= ends) && (t != abort_t);
            tick(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'b0, cnt);
        end
        readout();
    endtask

    task automatic reset_mid_run();
        start  = 1'b1;
        abort  = 1'b0;
        len    = 16'd30;
        warmup = 8'd2;
        seed   = 64'hDEAD_BEEF_0123_4567;
        Y_in   = '1;
        tick(1'b0, 0, 0, 1'b1, 1'b0);
        start = 1'b1;
        repeat (8) tick(1'b0, 0, 0, 1'b0, 1'b0);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 RST = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dp_en", 64'(dp_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_seed_load", 64'(seed_load), 64'd0);
        check("rst_seed_out", seed_out, 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        start = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NC; j++) mc[i][j] = 0;
        rd_hold  = '0;
        rd_pend  = 1'b0;
        seed_exp = '0;
        check("post_rst_done", 64'(done), 64'd0);
        readout();
    endtask

    initial begin
        int l, w, a;
        RST    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        len    = '0;
        warmup = '0;
        seed   = '0;
        Y_in   = '0;
        rd_en  = 1'b0;
        rd_row = '0;
        rd_col = '0;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NC; j++) mc[i][j] = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_dp_en", 64'(dp_en), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_seed_out", seed_out, 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        RST = 1'b0;

        do_run(10, 2, 64'hACE1, 0, 1);
        do_run(8, 0, 64'h1234_5678, 0, 2);
        do_run(0, 5, 64'hFFFF, 0, 0);
        do_run(20, 3, 64'h55AA, 1 + 3 + 5, 1);
        do_run(6, 1, 64'h0BAD_F00D, 0, 1);
        reset_mid_run();
        do_run(3, 0, 64'h77, 1, 1);
        do_run(4, 2, 64'h88, 3, 1);

        for (int r = 0; r < 14; r++) begin
            l = int'($urandom_range(0, 40));
            w = int'($urandom_range(0, 10));
            a = 0;
            if (l != 0 && ($urandom % 3) == 0) a = int'($urandom_range(1, 1 + w + l));
            do_run(l, w, {$urandom, $urandom}, a, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
